// File: rtl/instr_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch_queue_pkg
//  Description : Shared types and constants for the instruction prefetch
//                queue: fetch FSM encoding, default depth, word type.
//  Revision    : 1.0
// ============================================================================
package instr_prefetch_queue_pkg;

    // Default number of queue entries.
    localparam int unsigned IPQ_DEFAULT_DEPTH = 4;

    // 32-bit architectural word (addresses and instructions).
    typedef logic [31:0] word_t;

    // Fetch FSM: IDLE has no request out, WAIT keeps the returned word,
    // DISCARD lets a stale request finish but throws its data away.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic word_t word_align(input word_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_prefetch_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : Circular buffer of {PC, instruction} entries with head/tail
//                pointers, push, pop and a flush that empties it in one cycle.
//  Revision    : 1.0
// ============================================================================
module prefetch_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IPQ_DEFAULT_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [63:0]            push_data_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output logic [63:0]            head_data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_valid_o = !empty;
    assign head_data_o  = empty ? 64'h0 : mem_q[head_q];
    assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch_queue
//  Description : Instruction prefetcher. Keeps at most one memory request
//                outstanding, fills a queue of {PC, instruction} entries and
//                flushes/refetches on redirect. A request is only issued when
//                a queue slot is guaranteed for its data.
//  Revision    : 1.0
// ============================================================================
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = IPQ_DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   imem_req_o,
    output logic [31:0]            imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [31:0]            imem_data_i,
    output logic                   instr_valid_o,
    output logic [31:0]            instruction_o,
    output logic [31:0]            instr_pc_o,
    input  logic                   instr_taken_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    output logic [$clog2(DEPTH):0] queue_count_o
);
    localparam int unsigned CNT_W            = $clog2(DEPTH) + 1;
    localparam word_t       RESET_PC_ALIGNED = word_align(RESET_PC);

    fetch_state_e     state_q, state_d;
    word_t            fetch_pc_q, fetch_pc_d;
    word_t            addr_q, addr_d;
    logic             req_q, req_d;

    word_t            redirect_pc;
    logic             cpl;
    logic             push;
    logic             pop;
    logic             space;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic [63:0]      head_data;
    logic             head_valid;

    assign redirect_pc = word_align(redirect_pc_i);
    assign cpl         = req_q && imem_ack_i;
    // Redirect squashes both the consumer pop and any returning data.
    assign push        = cpl && (state_q == ST_WAIT) && !redirect_i;
    assign pop         = instr_taken_i && head_valid && !redirect_i;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    // Room for one more in-flight word once this edge's push/pop settle.
    assign space       = (count_after < CNT_W'(DEPTH));

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (redirect_i),
        .push_i       (push),
        .push_data_i  ({addr_q, imem_data_i}),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_data_o  (head_data),
        .count_o      (count)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i || space) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    state_d = cpl ? ST_WAIT : ST_DISCARD;
                end else if (cpl && !space) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (cpl) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: next request strobe, request address and fetch PC.
    always_comb begin
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    addr_d     = redirect_pc;
                    req_d      = 1'b1;
                end else if (space) begin
                    addr_d = fetch_pc_q;
                    req_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    // Without completion the old address must stay on the bus.
                    fetch_pc_d = redirect_pc;
                    if (cpl) begin
                        addr_d = redirect_pc;
                    end
                end else if (cpl) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (space) begin
                        addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        req_d = 1'b0;
                    end
                end
            end
            ST_DISCARD: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                end
                if (cpl) begin
                    addr_d = redirect_i ? redirect_pc : fetch_pc_q;
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Registered memory-side outputs and fetch PC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= 1'b0;
            addr_q     <= RESET_PC_ALIGNED;
            fetch_pc_q <= RESET_PC_ALIGNED;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = head_valid;
    assign instruction_o = head_data[31:0];
    assign instr_pc_o    = head_data[63:32];
    assign queue_count_o = count;

endmodule
`default_nettype wire
